shapool_controller: RTL and testbench
=====================================

// Module: shapool_controller
// PURPOSE
// Job sequencer for the shapool hashing pool. Accepts a job once the SPI loader has shifted in the
// midstate/header, then starts the pool once per nonce round and tracks the base nonce. It stops on
// the first core success or on nonce-space exhaustion, then raises READY and drives the status LED.
// Sits in top between the SPI0/SPI1 front ends and the pool of POOL_SIZE cores.
// PARAMETERS
// POOL_SIZE        1   number of hashing cores; POOL_SIZE = 2**POOL_SIZE_LOG2
// POOL_SIZE_LOG2   0   core-index bits, also used as the nonce offset bits
// NONCE_WIDTH      32  full nonce width
// BLINK_LOG2       22  LED blink half-period is 2**BLINK_LOG2 clk_in cycles
// PORTS
// clk_in            in   1         PLL global clock (g_clk)
// reset_in          in   1         synchronous, active-high reset
// job_valid_in      in   1         loader has a complete job; held until accepted
// job_ready_out     out  1         controller can accept a job (IDLE, FOUND, EXHAUSTED)
// halt_in           in   1         abort the current job (SPI1 readout asserted)
// pool_start_out    out  1         1-cycle pulse: cores load nonce_base_out and hash one round
// pool_done_in      in   1         1-cycle pulse: the round issued by the last start finished
// pool_success_in   in   POOL_SIZE per-core difficulty met; valid only with pool_done_in
// nonce_base_out    out  NB        NB = NONCE_WIDTH-POOL_SIZE_LOG2; core i hashes {base,i}
// winner_out        out  WW        WW = max(POOL_SIZE_LOG2,1); lowest successful core index
// result_valid_out  out  1         level: nonce_base_out/winner_out hold a result
// exhausted_out     out  1         level: nonce space swept without a result
// ready_out         out  1         1 = pull READY low; top maps this to ready_n_od_out open-drain
// status_led_n_out  out  1         active-low status indicator
// BEHAVIOUR
// - Reset: state=IDLE; every output 0 except job_ready_out=1 and status_led_n_out=1; nonce_base=0;
//   blink counter=0. Reset overrides every input in the same cycle and may arrive mid-round.
// - Job handshake: accepted on the edge where job_valid_in & job_ready_out. Acceptance clears
//   nonce_base, result_valid_out, exhausted_out, ready_out and winner_out, then moves to START.
// - States and transitions:
//   IDLE: wait for a job.
//   START: assert pool_start_out for exactly 1 cycle, then go to RUN.
//   RUN:
//     . pool_done_in & |pool_success_in -> FOUND. winner = lowest set bit; nonce_base is NOT incremented.
//     . pool_done_in, no success, nonce_base == all-ones -> EXHAUSTED. nonce_base wraps to 0.
//     . pool_done_in, otherwise -> nonce_base+1, then START. The next start comes 2 cycles after done.
//   FOUND: result_valid_out=1, ready_out=1; wait for a new job or halt.
//   EXHAUSTED: exhausted_out=1, ready_out=1; wait for a new job or halt.
// - pool_done_in seen outside RUN is ignored. pool_success_in is ignored without pool_done_in.
// - halt_in (any state): next state IDLE. Clears ready_out, result_valid_out and exhausted_out.
//   nonce_base_out and winner_out are held for readout.
//   halt_in has priority over a same-cycle job accept and over a same-cycle pool_done_in.
// - Simultaneous pool_done_in and job_valid_in in RUN: done wins; job_ready_out is 0 in RUN.
// - LED: IDLE = off (1). START/RUN = blink, LED = ~counter[BLINK_LOG2].
//   FOUND = on (0). EXHAUSTED = on for 1/8 of the blink period.
//   The counter runs free and wraps silently.
// - Output latency: every output is registered; responses appear 1 cycle after the causing edge.
// STRUCTURE
// - shapool_defines.vh holds the state encodings (IDLE=0, START=1, RUN=2, FOUND=3, EXHAUSTED=4,
//   3 bits) and the NB/WW width macros, shared with top and the bench.
// - Sub-module shapool_led_driver contains the blink counter and maps state to status_led_n_out.
// - Priority encoder for winner_out is a function inside the controller; there is no separate module.
// TESTING
// 1. Reset mid-RUN (nonce_base=5) -> next cycle IDLE, base=0, all outputs at reset values, LED=1.
// 2. Job accepted, done without success 3 times, then done with success=4'b0110 (POOL_SIZE=4)
//    -> 4 start pulses, each 2 cycles after done; FOUND, base=3, winner=1, result_valid=1, ready=1.
// 3. NONCE_WIDTH=6, POOL_SIZE_LOG2=2: 16 done pulses without success
//    -> EXHAUSTED, base=0, exhausted_out=1, ready_out=1, winner_out=0.
// 4. halt_in on the same cycle as pool_done_in with success -> IDLE; result_valid=0;
//    base unchanged; no FOUND.
// 5. In FOUND, job_valid_in=1 -> accepted; base=0, result_valid=0, ready=0, pool_start next cycle.
// 6. BLINK_LOG2=2 in RUN -> LED toggles every 4 cycles; FOUND -> LED steady 0.

Source files
------------

// File: rtl/shapool_controller_pkg.sv
// Shared types for the shapool job controller.
// state_e : controller state encoding, also consumed by the LED driver.
package shapool_controller_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StStart     = 3'd1,
    StRun       = 3'd2,
    StFound     = 3'd3,
    StExhausted = 3'd4
  } state_e;

endpackage

// File: rtl/shapool_controller_led_driver.sv
// Status LED driver for the shapool controller.
// Runs a free-running blink counter and maps the controller state to an active-low LED.
// Ports:
//   clk_in, reset_in  : clock, synchronous active-high reset
//   state_in          : current controller state
//   status_led_n_out  : registered active-low LED drive
module shapool_controller_led_driver
  import shapool_controller_pkg::*;
#(
  // Must be >= 2 so the exhausted duty cycle can use the top three counter bits.
  parameter int unsigned BLINK_LOG2 = 22
) (
  input  logic   clk_in,
  input  logic   reset_in,
  input  state_e state_in,
  output logic   status_led_n_out
);

  localparam int unsigned CW = BLINK_LOG2 + 1;

  logic [CW-1:0] cnt_q;
  logic          led_d;
  logic          led_q;

  always_comb begin
    led_d = 1'b1;
    case (state_in)
      StIdle:         led_d = 1'b1;
      StStart, StRun: led_d = ~cnt_q[BLINK_LOG2];
      StFound:        led_d = 1'b0;
      // Lit only while the top three bits are zero: 1/8 of a full blink period.
      StExhausted:    led_d = ~(cnt_q[BLINK_LOG2 -: 3] == 3'd0);
      default:        led_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cnt_q <= '0;
      led_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      led_q <= led_d;
    end
  end

  assign status_led_n_out = led_q;

endmodule

// File: rtl/shapool_controller.sv
// Job sequencer for the shapool hashing pool.
// Accepts a job, pulses pool_start_out once per nonce round, advances the base nonce, and stops
// on the first core success or when the nonce space is swept. halt_in aborts from any state.
// Ports:
//   clk_in, reset_in              : clock, synchronous active-high reset
//   job_valid_in / job_ready_out  : job handshake
//   halt_in                       : abort, holds nonce_base_out/winner_out for readout
//   pool_start_out                : 1-cycle round start, issued the cycle after START
//   pool_done_in, pool_success_in : round completion and per-core success
//   nonce_base_out, winner_out    : current base nonce and lowest successful core
//   result_valid_out, exhausted_out, ready_out : job outcome levels
//   status_led_n_out              : active-low status LED
module shapool_controller
  import shapool_controller_pkg::*;
#(
  parameter int unsigned POOL_SIZE      = 1,
  parameter int unsigned POOL_SIZE_LOG2 = 0,
  parameter int unsigned NONCE_WIDTH    = 32,
  parameter int unsigned BLINK_LOG2     = 22,
  localparam int unsigned NB = NONCE_WIDTH - POOL_SIZE_LOG2,
  localparam int unsigned WW = (POOL_SIZE_LOG2 > 0) ? POOL_SIZE_LOG2 : 1
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 job_valid_in,
  output logic                 job_ready_out,
  input  logic                 halt_in,
  output logic                 pool_start_out,
  input  logic                 pool_done_in,
  input  logic [POOL_SIZE-1:0] pool_success_in,
  output logic [NB-1:0]        nonce_base_out,
  output logic [WW-1:0]        winner_out,
  output logic                 result_valid_out,
  output logic                 exhausted_out,
  output logic                 ready_out,
  output logic                 status_led_n_out
);

  state_e        state_q, state_d;
  logic [NB-1:0] base_q, base_d;
  logic [WW-1:0] winner_q, winner_d;
  logic          start_q;

  function automatic logic [WW-1:0] lowest_set(input logic [POOL_SIZE-1:0] v);
    lowest_set = '0;
    for (int i = int'(POOL_SIZE) - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = WW'(i);
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    winner_d = winner_q;
    if (halt_in) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StFound, StExhausted: begin
          if (job_valid_in) begin
            state_d  = StStart;
            base_d   = '0;
            winner_d = '0;
          end
        end
        StStart: state_d = StRun;
        StRun: begin
          if (pool_done_in) begin
            if (|pool_success_in) begin
              state_d  = StFound;
              winner_d = lowest_set(pool_success_in);
            end else if (&base_q) begin
              state_d = StExhausted;
              base_d  = '0;
            end else begin
              state_d = StStart;
              base_d  = base_q + NB'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= StIdle;
      base_q   <= '0;
      winner_q <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      winner_q <= winner_d;
      // Start pulse lags START by a cycle; a halt during START suppresses it.
      start_q  <= (state_q == StStart) && !halt_in;
    end
  end

  assign job_ready_out    = (state_q == StIdle) || (state_q == StFound) ||
                            (state_q == StExhausted);
  assign pool_start_out   = start_q;
  assign nonce_base_out   = base_q;
  assign winner_out       = winner_q;
  assign result_valid_out = (state_q == StFound);
  assign exhausted_out    = (state_q == StExhausted);
  assign ready_out        = (state_q == StFound) || (state_q == StExhausted);

  shapool_controller_led_driver #(
    .BLINK_LOG2(BLINK_LOG2)
  ) u_led (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .state_in        (state_q),
    .status_led_n_out(status_led_n_out)
  );

endmodule

// File: tb/tb_shapool_controller.sv
module tb_shapool_controller;
  localparam int PS   = 4;
  localparam int PL   = 2;
  localparam int NW   = 6;
  localparam int BL   = 2;
  localparam int NB   = NW - PL;
  localparam int WW   = 2;
  localparam int MAXB = (1 << NB) - 1;

  // Abstract job status kept by the reference model.
  localparam int MIdle = 0, MBusy = 1, MFound = 2, MExh = 3;
  localparam int EvStart = 0, EvFound = 1, EvExh = 2;

  logic          clk = 1'b0;
  logic          rst, job_valid, halt, pool_done;
  logic [PS-1:0] pool_success;
  logic          job_ready, pool_start, rv, ex, rdy, led;
  logic [NB-1:0] base;
  logic [WW-1:0] winner;

  int checks = 0, failures = 0, cyc = 0;
  int m_state = MIdle, m_base = 0, m_winner = 0;

  typedef struct {int kind; int cyc; int base; int winner;} ev_t;
  ev_t exp_q[$];
  logic prv_rv, prv_ex;

  shapool_controller #(
    .POOL_SIZE(PS), .POOL_SIZE_LOG2(PL), .NONCE_WIDTH(NW), .BLINK_LOG2(BL)
  ) dut (
    .clk_in          (clk),
    .reset_in        (rst),
    .job_valid_in    (job_valid),
    .job_ready_out   (job_ready),
    .halt_in         (halt),
    .pool_start_out  (pool_start),
    .pool_done_in    (pool_done),
    .pool_success_in (pool_success),
    .nonce_base_out  (base),
    .winner_out      (winner),
    .result_valid_out(rv),
    .exhausted_out   (ex),
    .ready_out       (rdy),
    .status_led_n_out(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a start or a new outcome.
  task automatic got(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_kind", kind, e.kind);
    chk("ev_cycle", cyc, e.cyc);
    chk("ev_base", int'(base), e.base);
    chk("ev_winner", int'(winner), e.winner);
    chk("ev_ready", int'(rdy), int'(kind != EvStart));
    chk("ev_job_ready", int'(job_ready), int'(kind != EvStart));
    if (kind == EvStart) chk("ev_stale_result", int'(rv | ex), 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (pool_start) got(EvStart);
      if (rv && !prv_rv) got(EvFound);
      if (ex && !prv_ex) got(EvExh);
    end
    prv_rv <= rv;
    prv_ex <= ex;
  end

  function automatic int lowest(input int v);
    return $clog2(v & (-v));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c, input int b, input int w);
    ev_t e;
    e.kind = kind; e.cyc = c; e.base = b; e.winner = w;
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_job_ready"}, int'(job_ready), 1);
    chk({tag, "_start"}, int'(pool_start), 0);
    chk({tag, "_result_valid"}, int'(rv), 0);
    chk({tag, "_exhausted"}, int'(ex), 0);
    chk({tag, "_ready"}, int'(rdy), 0);
    chk({tag, "_base"}, int'(base), 0);
    chk({tag, "_winner"}, int'(winner), 0);
    chk({tag, "_led"}, int'(led), 1);
  endtask

  task automatic accept_job();
    job_valid = 1'b1;
    push(EvStart, cyc + 2, 0, 0);
    m_state = MBusy; m_base = 0; m_winner = 0;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_start();
    bit seen = 0;
    int n = 0;
    while (!seen && n < 8) begin
      @(negedge clk);
      seen = pool_start;
      n++;
    end
    if (!seen) chk("start_timeout", 0, 1);
    tick();
  endtask

  task automatic do_done(input int succ, input bit hlt, input bit jv);
    pool_done = 1'b1; pool_success = PS'(succ); halt = hlt; job_valid = jv;
    if (hlt) begin
      m_state = MIdle;
    end else if (succ != 0) begin
      m_winner = lowest(succ);
      m_state  = MFound;
      push(EvFound, cyc + 1, m_base, m_winner);
    end else if (m_base == MAXB) begin
      m_base  = 0;
      m_state = MExh;
      push(EvExh, cyc + 1, 0, m_winner);
    end else begin
      m_base++;
      push(EvStart, cyc + 2, m_base, m_winner);
    end
    tick();
    pool_done = 1'b0; pool_success = '0; halt = 1'b0; job_valid = 1'b0;
  endtask

  task automatic count_led(input int n, output int zeros, output int toggles, output bit even);
    logic last;
    int   last_t = -1;
    zeros = 0; toggles = 0; even = 1;
    @(negedge clk);
    last = led;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (led == 1'b0) zeros++;
      if (led != last) begin
        if (last_t >= 0 && (i - last_t) != 4) even = 0;
        last_t = i;
        toggles++;
      end
      last = led;
    end
    tick();
  endtask

  initial begin
    int zeros, toggles, rounds;
    bit even;
    rst = 1'b1; job_valid = 1'b0; halt = 1'b0; pool_done = 1'b0; pool_success = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset("init");
    tick();

    // Reset in the middle of a run with base 5.
    accept_job();
    for (int i = 0; i < 5; i++) begin
      wait_start();
      do_done(0, 0, 0);
    end
    wait_start();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_state = MIdle; m_base = 0; m_winner = 0;
    @(negedge clk);
    check_reset("midrun_reset");
    tick();

    // Three misses then success 0110: found at base 3, winner 1.
    accept_job();
    for (int i = 0; i < 3; i++) begin
      wait_start();
      do_done(0, 0, 0);
    end
    wait_start();
    do_done(4'b0110, 0, 0);
    tick();
    count_led(8, zeros, toggles, even);
    chk("found_led_steady_on", zeros, 8);

    // New job from FOUND, blink check in RUN, then halt racing a successful done.
    accept_job();
    wait_start();
    count_led(20, zeros, toggles, even);
    chk("run_led_toggles", int'(toggles >= 4), 1);
    chk("run_led_period", int'(even), 1);
    do_done(0, 0, 0);
    wait_start();
    do_done(0, 0, 0);
    wait_start();
    do_done(4'b0011, 1, 0);
    @(negedge clk);
    chk("halt_done_result_valid", int'(rv), 0);
    chk("halt_done_job_ready", int'(job_ready), 1);
    chk("halt_done_base_held", int'(base), 2);
    tick();

    // Sweep the whole nonce space without success.
    accept_job();
    for (int i = 0; i <= MAXB; i++) begin
      wait_start();
      do_done(0, 0, 0);
    end
    tick();
    count_led(16, zeros, toggles, even);
    chk("exhausted_led_duty", zeros, 2);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    m_state = MIdle;
    @(negedge clk);
    chk("halt_exh_exhausted", int'(ex), 0);
    chk("halt_exh_ready", int'(rdy), 0);
    tick();

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      if ($urandom_range(0, 2) == 0) begin
        pool_done = 1'b1; pool_success = PS'($urandom);
        tick();
        pool_done = 1'b0; pool_success = '0;
        @(negedge clk);
        chk("spurious_done_base", int'(base), m_base);
        chk("spurious_done_winner", int'(winner), m_winner);
        tick();
      end
      accept_job();
      rounds = 0;
      while (m_state == MBusy && rounds < 40) begin
        wait_start();
        repeat ($urandom_range(0, 2)) begin
          pool_success = PS'($urandom);
          tick();
        end
        if ($urandom_range(0, 9) == 0)
          do_done(int'($urandom_range(0, 15)), 1, 0);
        else if ($urandom_range(0, 3) == 0)
          do_done(int'($urandom_range(1, 15)), 0, bit'($urandom_range(0, 1)));
        else
          do_done(0, 0, bit'($urandom_range(0, 1)));
        rounds++;
      end
      if (m_state == MFound && $urandom_range(0, 2) == 0) begin
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        m_state = MIdle;
        @(negedge clk);
        chk("halt_found_result_valid", int'(rv), 0);
        chk("halt_found_winner_held", int'(winner), m_winner);
        chk("halt_found_base_held", int'(base), m_base);
        tick();
      end
    end

    repeat (6) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
